// File: rtl/normalization_packer_pkg.sv
// Shared definitions for the normalization packer: the packer state type,
// the element-count width helper and the count-to-contiguous-mask helper.
package normalization_packer_pkg;

    // Widest beat the mask helper supports.
    localparam int MAX_ELEMENTS = 64;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } packer_state_t;

    // Width of an element count able to hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Contiguous mask with the low 'count' bits set.
    function automatic logic [MAX_ELEMENTS-1:0] keep_from_count(input int unsigned count);
        logic [MAX_ELEMENTS:0] one;
        one = (MAX_ELEMENTS+1)'(1);
        return MAX_ELEMENTS'((one << count) - one);
    endfunction

endpackage

// File: rtl/normalization_packer_if.sv
// Element-vector beat bus: data elements packed at low indices, a keep mask,
// a frame-end marker and a valid/ready handshake.
interface ndata_i #(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 8
);
    data_t [NUM_ELEMENTS-1:0] data;
    logic  [NUM_ELEMENTS-1:0] keep;
    logic                     last;
    logic                     valid;
    logic                     ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/normalization_packer_merge.sv
// Combinational merge of the residue buffer with an incoming beat. Produces
// the merged vector (residue followed by the new elements), the spill of new
// elements that did not fit (moved down to index 0) and the total count.
module normalization_merge
    import normalization_packer_pkg::*;
#(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 8,
    parameter int  CNT_WIDTH    = cnt_width(NUM_ELEMENTS)
) (
    input  data_t [NUM_ELEMENTS-1:0] residue_i,
    input  logic  [CNT_WIDTH-1:0]    fill_i,
    input  data_t [NUM_ELEMENTS-1:0] data_i,
    input  logic  [CNT_WIDTH-1:0]    count_i,
    output data_t [NUM_ELEMENTS-1:0] merged_o,
    output data_t [NUM_ELEMENTS-1:0] spill_o,
    output logic  [CNT_WIDTH:0]      total_o
);

    localparam int IW = $clog2(NUM_ELEMENTS);

    assign total_o = {1'b0, fill_i} + {1'b0, count_i};

    // Residue occupies the low F slots, new elements follow; elements pushed
    // past the top of the beat wrap down into the spill vector.
    always_comb begin
        merged_o = '0;
        spill_o  = '0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            if (j < int'(fill_i)) begin
                merged_o[j] = residue_i[j];
                spill_o[j]  = data_i[IW'(NUM_ELEMENTS - int'(fill_i) + j)];
            end else begin
                merged_o[j] = data_i[IW'(j - int'(fill_i))];
            end
        end
    end

endmodule

// File: rtl/normalization_packer.sv
// Normalization packer: re-packs variable-occupancy beats into dense
// NUM_ELEMENTS-wide beats, carrying residue across beats and flushing a final
// partial beat at frame end. Optional macro NORMALIZATION_PACKER_KEEP_CHECK_EN
// adds a sticky keep_error flag for non-contiguous keep masks.
module normalization_packer
    import normalization_packer_pkg::*;
#(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 8,
    parameter int  CNT_WIDTH    = cnt_width(NUM_ELEMENTS)
) (
    input  logic clk,
    input  logic rst,
    ndata_i.s    in,
    ndata_i.m    out
`ifdef NORMALIZATION_PACKER_KEEP_CHECK_EN
    ,
    output logic keep_error
`endif
);

    typedef data_t [NUM_ELEMENTS-1:0] vec_t;

    localparam logic [CNT_WIDTH:0] FULL = (CNT_WIDTH+1)'(NUM_ELEMENTS);

    packer_state_t             state_q, state_d;
    logic [CNT_WIDTH-1:0]      fill_q, fill_d;
    vec_t                      residue_q, residue_d;
    vec_t                      outData_q, outData_d;
    logic [NUM_ELEMENTS-1:0]   outKeep_q, outKeep_d;
    logic                      outLast_q, outLast_d;
    logic                      outValid_q, outValid_d;

    logic [CNT_WIDTH-1:0]      beatCount;
    logic [CNT_WIDTH:0]        totalCount;
    vec_t                      merged;
    vec_t                      spill;
    logic                      slotFree;
    logic                      inReady;
    logic                      accept;
    logic                      flushFire;
    logic                      overflow;

    assign beatCount = CNT_WIDTH'($countones(in.keep));

    normalization_merge #(
        .data_t       (data_t),
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .CNT_WIDTH    (CNT_WIDTH)
    ) uMerge (
        .residue_i (residue_q),
        .fill_i    (fill_q),
        .data_i    (in.data),
        .count_i   (beatCount),
        .merged_o  (merged),
        .spill_o   (spill),
        .total_o   (totalCount)
    );

    assign slotFree  = !outValid_q || out.ready;
    assign accept    = in.valid && inReady;
    assign flushFire = (state_q == FLUSH) && slotFree;
    assign overflow  = totalCount > FULL;

    assign in.ready  = inReady;
    assign out.data  = outData_q;
    assign out.keep  = outKeep_q;
    assign out.last  = outLast_q;
    assign out.valid = outValid_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Enter FLUSH when a last beat overflows one output beat; leave once the residue is emitted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && in.last && overflow) state_d = FLUSH;
            FLUSH:   if (slotFree) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Input is accepted only in RUN and only when the output register can take a new beat.
    always_comb begin
        inReady = 1'b0;
        case (state_q)
            RUN:     inReady = slotFree;
            FLUSH:   inReady = 1'b0;
            default: inReady = 1'b0;
        endcase
    end

    // Datapath next-state: merge, emit full or final beats, and flush leftover residue.
    always_comb begin
        fill_d     = fill_q;
        residue_d  = residue_q;
        outData_d  = outData_q;
        outKeep_d  = outKeep_q;
        outLast_d  = outLast_q;
        outValid_d = outValid_q && !out.ready;
        if (accept) begin
            if (!in.last && (totalCount < FULL)) begin
                residue_d = merged;
                fill_d    = CNT_WIDTH'(totalCount);
            end else if (in.last && !overflow) begin
                outValid_d = 1'b1;
                outData_d  = merged;
                outKeep_d  = NUM_ELEMENTS'(keep_from_count(32'(totalCount)));
                outLast_d  = 1'b1;
                fill_d     = '0;
            end else begin
                outValid_d = 1'b1;
                outData_d  = merged;
                outKeep_d  = '1;
                outLast_d  = 1'b0;
                residue_d  = spill;
                fill_d     = CNT_WIDTH'(totalCount - FULL);
            end
        end else if (flushFire) begin
            outValid_d = 1'b1;
            outData_d  = residue_q;
            outKeep_d  = NUM_ELEMENTS'(keep_from_count(32'(fill_q)));
            outLast_d  = 1'b1;
            fill_d     = '0;
        end
    end

    // Datapath registers; reset drops any buffered residue and pending output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q     <= '0;
            residue_q  <= '0;
            outData_q  <= '0;
            outKeep_q  <= '0;
            outLast_q  <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            residue_q  <= residue_d;
            outData_q  <= outData_d;
            outKeep_q  <= outKeep_d;
            outLast_q  <= outLast_d;
            outValid_q <= outValid_d;
        end
    end

`ifdef NORMALIZATION_PACKER_KEEP_CHECK_EN
    localparam logic [NUM_ELEMENTS-1:0] KEEP_ONE = NUM_ELEMENTS'(1);

    logic keepContiguous;
    logic keepError_q;

    assign keepContiguous = ((in.keep & (in.keep + KEEP_ONE)) == '0);
    assign keep_error     = keepError_q;

    // Sticky flag raised by any accepted beat whose keep is not of the form 2^k-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          keepError_q <= 1'b0;
        else if (accept && !keepContiguous) keepError_q <= 1'b1;
    end

    keepContiguousCheck: assert property (@(posedge clk) disable iff (rst) accept |-> keepContiguous)
        else $error("normalization_packer: non-contiguous keep accepted");
`endif

endmodule

// File: tb/tb_normalization_packer.sv
// Self-checking bench for normalization_packer (N=8, byte elements). A
// queue-based element model predicts every output beat; randomized frames and
// output backpressure exercise residue carry, flush and stall stability.
// Keep-check tests are compiled only with NORMALIZATION_PACKER_KEEP_CHECK_EN.
module tb_normalization_packer;

    localparam int N = 8;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic clk;
    logic rst;
`ifdef NORMALIZATION_PACKER_KEEP_CHECK_EN
    logic keepError;
`endif

    ndata_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(N)) inIf ();
    ndata_i #(.data_t(logic [7:0]), .NUM_ELEMENTS(N)) outIf ();

    normalization_packer #(
        .data_t       (logic [7:0]),
        .NUM_ELEMENTS (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (inIf),
        .out        (outIf)
`ifdef NORMALIZATION_PACKER_KEEP_CHECK_EN
        ,
        .keep_error (keepError)
`endif
    );

    int          testsRun = 0;
    int          failCount = 0;
    int          cycleCount = 0;
    int          readyMode = 0;
    logic [7:0]  pendQ[$];
    beat_t       expQ[$];
    logic        stallPrev = 1'b0;
    logic [63:0] savedData;
    logic [63:0] savedCtrl;
    beat_t       expBeat;

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] keepMask(input logic [7:0] k);
        logic [63:0] m;
        for (int i = 0; i < N; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    // Element-stream model: pop k pending elements into an expected output beat.
    task automatic emitBeat(input int k, input logic last);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < k; i++) b.data[i*8 +: 8] = pendQ.pop_front();
        b.keep = 8'((16'd1 << k) - 16'd1);
        b.last = last;
        expQ.push_back(b);
    endtask

    task automatic modelAccept(input logic [63:0] data, input logic [7:0] keep, input logic last);
        int c;
        c = $countones(keep);
        for (int i = 0; i < c; i++) pendQ.push_back(data[i*8 +: 8]);
        if (!last) begin
            if (pendQ.size() >= N) emitBeat(N, 1'b0);
        end else begin
            if (pendQ.size() > N) emitBeat(N, 1'b0);
            emitBeat(pendQ.size(), 1'b1);
        end
    endtask

    // Sink: drive out.ready after each edge, always-ready or 50% random.
    initial begin
        outIf.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            outIf.ready = (readyMode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor at the falling edge: feed accepted beats to the model, score output transfers, check stall stability.
    always @(negedge clk) begin
        if (rst) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("stall_data", outIf.data, savedData);
                checkOutput("stall_ctrl", {54'd0, outIf.valid, outIf.last, outIf.keep}, savedCtrl);
            end
            if (outIf.valid && outIf.ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    expBeat = expQ.pop_front();
                    checkOutput("out_keep", {56'd0, outIf.keep}, {56'd0, expBeat.keep});
                    checkOutput("out_last", {63'd0, outIf.last}, {63'd0, expBeat.last});
                    checkOutput("out_data", outIf.data & keepMask(expBeat.keep), expBeat.data);
                end
            end
            if (inIf.valid && inIf.ready) modelAccept(inIf.data, inIf.keep, inIf.last);
            stallPrev = outIf.valid && !outIf.ready;
            savedData = outIf.data;
            savedCtrl = {54'd0, outIf.valid, outIf.last, outIf.keep};
        end
    end

    // Present one beat (called just after a rising edge) and hold it until accepted.
    task automatic applyStimulus(input logic [63:0] data, input logic [7:0] keep, input logic last, output int waits);
        waits = 0;
        inIf.data  = data;
        inIf.keep  = keep;
        inIf.last  = last;
        inIf.valid = 1'b1;
        forever begin
            @(negedge clk);
            if (inIf.ready) break;
            waits++;
            if (waits > 1000) begin
                checkOutput("in_ready_timeout", 64'(waits), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        inIf.valid = 1'b0;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        inIf.valid = 1'b0;
        pendQ.delete();
        expQ.delete();
        @(negedge clk);
        checkOutput("rst_valid", {63'd0, outIf.valid}, 64'd0);
        checkOutput("rst_keep", {56'd0, outIf.keep}, 64'd0);
        checkOutput("rst_last", {63'd0, outIf.last}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", {63'd0, inIf.ready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        checkOutput(tag, 64'(expQ.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence of directed and randomized frames.
    initial begin
        int          waits;
        int          c;
        int          beats;
        int          startCycle;
        logic [7:0]  k;

        rst        = 1'b0;
        inIf.valid = 1'b0;
        inIf.data  = '0;
        inIf.keep  = '0;
        inIf.last  = 1'b0;
        #1;
        pulseReset();

        // Frame of four 3-element beats: one full beat then keep=0x0F last.
        readyMode = 0;
        for (int b = 0; b < 4; b++) applyStimulus({$urandom, $urandom}, 8'h07, 1'(b == 3), waits);
        waitDrain("drain_frame3");

        // 100 back-to-back full beats at one beat per cycle.
        startCycle = cycleCount;
        for (int b = 0; b < 100; b++) begin
            applyStimulus({$urandom, $urandom}, 8'hFF, 1'b0, waits);
            checkOutput("tput_in_ready", 64'(waits), 64'd0);
        end
        checkOutput("tput_cycles", 64'(cycleCount - startCycle), 64'd100);
        waitDrain("drain_tput");

        // F=5 then last C=7: full beat, then flush of 4 with one cycle of in.ready low.
        applyStimulus({$urandom, $urandom}, 8'h1F, 1'b0, waits);
        applyStimulus({$urandom, $urandom}, 8'h7F, 1'b1, waits);
        @(negedge clk);
        checkOutput("flush_ready_low", {63'd0, inIf.ready}, 64'd0);
        @(negedge clk);
        checkOutput("flush_ready_back", {63'd0, inIf.ready}, 64'd1);
        @(posedge clk);
        #1;
        waitDrain("drain_flush");

        // Empty frame emits a keep=0 last=1 marker.
        applyStimulus({$urandom, $urandom}, 8'h00, 1'b1, waits);
        waitDrain("drain_empty");

        // Reset with 6 buffered elements; the next frame must carry no stale residue.
        applyStimulus({$urandom, $urandom}, 8'h3F, 1'b0, waits);
        pulseReset();
        applyStimulus({$urandom, $urandom}, 8'h03, 1'b1, waits);
        waitDrain("drain_after_rst");

        // Random frames under 50% output backpressure.
        readyMode = 1;
        for (int f = 0; f < 1000; f++) begin
            beats = $urandom_range(1, 3);
            for (int b = 0; b < beats; b++) begin
                c = $urandom_range(0, N);
                k = 8'((16'd1 << c) - 16'd1);
                applyStimulus({$urandom, $urandom}, k, 1'(b == beats - 1), waits);
            end
        end
        waitDrain("drain_random");
        readyMode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_valid", {63'd0, outIf.valid}, 64'd0);
        @(posedge clk);
        #1;

`ifdef NORMALIZATION_PACKER_KEEP_CHECK_EN
        // Non-contiguous keep raises the sticky error flag until reset.
        @(negedge clk);
        checkOutput("keep_err_clear", {63'd0, keepError}, 64'd0);
        @(posedge clk);
        #1;
        applyStimulus({$urandom, $urandom}, 8'h05, 1'b0, waits);
        @(negedge clk);
        checkOutput("keep_err_set", {63'd0, keepError}, 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("keep_err_sticky", {63'd0, keepError}, 64'd1);
        pulseReset();
        @(negedge clk);
        checkOutput("keep_err_rst", {63'd0, keepError}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
